// File: rtl/exp_result_buffer.sv
// Elastic output stage for the exp evaluator: Q7.25 -> Q4.12 round/saturate,
// small FWFT FIFO with back-pressure and saturating debug counters.
module exp_result_buffer #(
  parameter int WIDTHIN  = 32,
  parameter int WIDTHOUT = 16,
  parameter int DEPTH    = 4,
  parameter int CNTW     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [WIDTHIN-1:0]  i_y,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [WIDTHOUT-1:0] o_z,
  output logic [CNTW-1:0]     o_result_cnt,
  output logic [CNTW-1:0]     o_sat_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   OCC_ONE = (AW+1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

  logic [WIDTHOUT-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         occ;

  logic [15:0] t;
  logic        r;
  logic        sat;
  logic [15:0] z;
  logic        full;
  logic        empty;
  logic        wr;
  logic        rd;
  logic        unused_lsb;

  // Fraction bits below the rounding bit never reach the output
  assign unused_lsb = ^i_y[11:0];

  assign t   = i_y[28:13];
  assign r   = i_y[12];
  assign sat = (|i_y[31:29]) | ((&t) & r);

  always_comb begin
    z = t + {15'd0, r};
    unique case (1'b1)
      sat:     z = 16'hFFFF;
      default: ;
    endcase
  end

  assign full  = (occ == OCC_FULL);
  assign empty = (occ == '0);

  assign o_ready = ~full & reset;
  assign o_valid = ~empty;
  assign o_z     = mem[rd_ptr];

  assign wr = i_valid & o_ready;
  assign rd = o_valid & i_ready;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= z;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr, rd})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: ;
      endcase
    end
  end

  // Debug counters stick at all-ones rather than wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_result_cnt <= '0;
      o_sat_cnt    <= '0;
    end else if (wr) begin
      if (o_result_cnt != '1)
        o_result_cnt <= o_result_cnt + CNTW'(1);
      if (sat && o_sat_cnt != '1)
        o_sat_cnt <= o_sat_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_exp_result_buffer.sv
// Bench for exp_result_buffer: queue-based reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_exp_result_buffer;

  localparam int DEPTH = 4;
  localparam int CNTW  = 4;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [31:0]     i_y = '0;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [15:0]     o_z;
  logic [CNTW-1:0] o_result_cnt;
  logic [CNTW-1:0] o_sat_cnt;

  int checks = 0;
  int errors = 0;

  exp_result_buffer #(
    .WIDTHIN(32), .WIDTHOUT(16), .DEPTH(DEPTH), .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_y(i_y),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_z(o_z),
    .o_result_cnt(o_result_cnt),
    .o_sat_cnt(o_sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: value scaled to 2^-12 units, rounded half up, clipped
  function automatic logic [15:0] ref_conv(input logic [31:0] y,
                                           output bit s);
    longint v;
    v = {32'd0, y};
    v = (v + 64'd4096) >> 13;
    s = (v > 65535);
    ref_conv = s ? 16'hFFFF : v[15:0];
  endfunction

  logic [15:0] q[$];
  int rcnt = 0;
  int scnt = 0;
  bit m_wr, m_rd, m_sat;
  logic [15:0] m_z;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      rcnt = 0;
      scnt = 0;
    end else begin
      m_wr = i_valid && (q.size() < DEPTH);
      m_rd = i_ready && (q.size() > 0);
      if (m_rd) void'(q.pop_front());
      if (m_wr) begin
        m_z = ref_conv(i_y, m_sat);
        q.push_back(m_z);
        rcnt++;
        if (m_sat) scnt++;
      end
    end
  end

  always @(negedge clk) begin
    chk("o_valid", {31'd0, o_valid}, {31'd0, q.size() > 0});
    chk("o_ready", {31'd0, o_ready},
        {31'd0, reset && (q.size() < DEPTH)});
    if (q.size() > 0) chk("o_z", {16'd0, o_z}, {16'd0, q[0]});
    chk("result_cnt", {28'd0, o_result_cnt}, (rcnt > CMAX) ? CMAX : rcnt);
    chk("sat_cnt", {28'd0, o_sat_cnt}, (scnt > CMAX) ? CMAX : scnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] fw [5];

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1 chk("ready_after_reset", {31'd0, o_ready}, 32'd1);

    // Rounding
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_y = 32'h02000000; tick();
    i_y = 32'h02001000; tick();
    i_y = 32'h02000FFF; tick();
    i_valid = 1'b0;
    chk("round_a", {16'd0, o_z}, 32'h1000);
    chk("round_rc", {28'd0, o_result_cnt}, 32'd3);
    chk("round_sc", {28'd0, o_sat_cnt}, 32'd0);
    i_ready = 1'b1; tick();
    chk("round_b", {16'd0, o_z}, 32'h1001);
    tick();
    chk("round_c", {16'd0, o_z}, 32'h1000);
    tick();
    chk("round_empty", {31'd0, o_valid}, 32'd0);

    // Saturation
    rst_pulse();
    i_valid = 1'b1;
    i_y = 32'h20000000; tick();
    i_y = 32'h1FFFF000; tick();
    i_y = 32'h1FFFE000; tick();
    i_valid = 1'b0;
    chk("sat_a", {16'd0, o_z}, 32'hFFFF);
    chk("sat_sc", {28'd0, o_sat_cnt}, 32'd2);
    chk("sat_rc", {28'd0, o_result_cnt}, 32'd3);
    i_ready = 1'b1; tick();
    chk("sat_b", {16'd0, o_z}, 32'hFFFF);
    tick();
    chk("sat_c", {16'd0, o_z}, 32'hFFFF);
    tick();

    // Fill and back-pressure
    rst_pulse();
    fw[0] = 32'h02000000;
    fw[1] = 32'h02400000;
    fw[2] = 32'h04002000;
    fw[3] = 32'h00001000;
    fw[4] = 32'h1FFFE000;
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_y = fw[k];
      tick();
    end
    chk("fill_ready_low", {31'd0, o_ready}, 32'd0);
    i_y = fw[4];
    tick();
    tick();
    chk("fill_held", {31'd0, o_ready}, 32'd0);
    chk("fill_rc", {28'd0, o_result_cnt}, 32'd4);
    chk("fill_head", {16'd0, o_z}, 32'h1000);
    i_ready = 1'b1;
    tick();
    chk("fill_ready_up", {31'd0, o_ready}, 32'd1);
    chk("fill_head2", {16'd0, o_z}, 32'h1200);
    tick();
    i_valid = 1'b0;
    chk("fill_head3", {16'd0, o_z}, 32'h2001);
    tick();
    chk("fill_head4", {16'd0, o_z}, 32'h0001);
    tick();
    chk("fill_head5", {16'd0, o_z}, 32'hFFFF);
    tick();
    chk("fill_empty", {31'd0, o_valid}, 32'd0);
    chk("fill_rc5", {28'd0, o_result_cnt}, 32'd5);
    chk("fill_sc0", {28'd0, o_sat_cnt}, 32'd0);

    // Streaming
    rst_pulse();
    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_y = 32'h00123000 * (k + 1);
      tick();
    end
    i_valid = 1'b0;
    chk("stream_rc", {28'd0, o_result_cnt}, 32'hF);
    tick();
    chk("stream_empty", {31'd0, o_valid}, 32'd0);

    // Counter saturation
    rst_pulse();
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_y = 32'hE0000000;
    for (int k = 0; k < 20; k++) tick();
    i_valid = 1'b0;
    chk("csat_rc", {28'd0, o_result_cnt}, 32'hF);
    chk("csat_sc", {28'd0, o_sat_cnt}, 32'hF);
    tick();

    // Asynchronous reset mid-stream
    rst_pulse();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_y = 32'h02000000; tick();
    i_y = 32'h02400000; tick();
    i_y = 32'h04002000; tick();
    i_valid = 1'b0;
    chk("ar_pre_valid", {31'd0, o_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", {31'd0, o_valid}, 32'd0);
    chk("ar_ready", {31'd0, o_ready}, 32'd0);
    chk("ar_rc", {28'd0, o_result_cnt}, 32'd0);
    chk("ar_sc", {28'd0, o_sat_cnt}, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("ar_ready_rel", {31'd0, o_ready}, 32'd1);
    chk("ar_empty_rel", {31'd0, o_valid}, 32'd0);
    i_valid = 1'b1;
    i_y = 32'h00800000;
    tick();
    i_valid = 1'b0;
    chk("ar_new_valid", {31'd0, o_valid}, 32'd1);
    chk("ar_new_head", {16'd0, o_z}, 32'h0400);
    chk("ar_new_rc", {28'd0, o_result_cnt}, 32'd1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp_result_buffer.md
# exp_result_buffer

Elastic output stage that sits directly downstream of the pipelined exponential (Taylor) evaluator. It accepts Q7.25 results over a valid/ready handshake and converts each one to unsigned Q4.12 with round-half-up and saturation. Converted words are buffered in a small first-word-fall-through FIFO. Its `o_ready` drives the evaluator's ready input, so back-pressure from the final consumer stalls the whole evaluator pipeline instead of dropping results. It also keeps saturating result and saturation counters for debug.

## Interface
- `WIDTHIN`, 32: input width, Q7.25; the block supports only 32.
- `WIDTHOUT`, 16: output width, Q4.12; the block supports only 16.
- `DEPTH`, 4: number of FIFO entries; must be a power of 2, minimum 2.
- `CNTW`, 16: width of the statistics counters.

Ports:
- `clk` in 1: clock; every register is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_valid` in 1: upstream result valid.
- `o_ready` out 1: buffer can accept; connects to the evaluator's ready input.
- `i_y` in 32: upstream result, Q7.25 unsigned.
- `o_valid` out 1: buffer head is valid.
- `i_ready` in 1: downstream consumer ready.
- `o_z` out 16: buffer head, Q4.12 unsigned.
- `o_result_cnt` out CNTW: number of accepted results; saturating.
- `o_sat_cnt` out CNTW: number of accepted results that saturated; saturating.

## Operation
- Handshake rules:
  - Write: `i_valid & o_ready`.
  - Read: `o_valid & i_ready`.
  - Data is neither lost nor duplicated.
- Conversion is combinational on `i_y` and happens at write time; only the 16-bit result is stored.
  - Truncated value: `t = i_y[28:13]`.
  - Round bit: `r = i_y[12]`.
  - Saturate when `i_y[31:29] != 0`, or when `t == 16'hFFFF` and `r == 1`. The stored word is then `16'hFFFF`.
  - Otherwise the stored word is `t + r`.
  - Bits `[11:0]` are discarded after rounding.
- FIFO state:
  - Read pointer and write pointer, each `log2(DEPTH)` bits, wrapping modulo DEPTH.
  - Occupancy register, `log2(DEPTH)+1` bits.
  - Full when occupancy == DEPTH; empty when occupancy == 0.
- `o_ready = ~full`, and it is forced to 0 while `reset` is low.
- `o_valid = ~empty`; `o_z` = entry at the read pointer (first-word fall-through).
- Simultaneous write and read:
  - Non-empty and not full: both happen, occupancy unchanged, and both pointers advance.
  - Full: a write is impossible (`o_ready` = 0) even if a read occurs that cycle. The freed slot becomes writable in the next cycle.
  - Empty: no read (`o_valid` = 0). The write lands and appears on `o_z` in the next cycle; there is no bypass.
- Counters:
  - `o_result_cnt` increments on every write.
  - `o_sat_cnt` increments on every write that saturated.
  - Both hold at all-ones (`2^CNTW-1`) and do not wrap.
- When the consumer does not read, `o_z` and `o_valid` stay stable until the head is read.
- `i_y` is ignored when `i_valid` is 0. While full, the block does not sample `i_y`.

## Timing
- Reset values: pointers 0, occupancy 0, `o_valid` 0, `o_ready` 0 while `reset` is low, `o_result_cnt` 0, `o_sat_cnt` 0. Storage contents are don't-care.
- After `reset` deasserts, `o_ready` = 1 combinationally in the same cycle, because the FIFO is empty.
- Latency:
  - A write at rising edge N gives `o_valid` = 1 and `o_z` = converted word from edge N onward.
  - The earliest read is edge N+1.
- Throughput: one write and one read per cycle in steady state.
- `o_ready` and `o_valid` depend only on registered state and `reset`; there is no combinational path from `i_valid` or `i_ready`.
- Reset mid-operation: all buffered data and counts are discarded immediately (asynchronous). `o_valid` falls without a handshake.

## Test plan
- Rounding:
  - `i_y=32'h02000000` -> `o_z=16'h1000`.
  - `i_y=32'h02001000` -> `o_z=16'h1001`.
  - `i_y=32'h02000FFF` -> `o_z=16'h1000`.
  - `o_sat_cnt` stays 0 and `o_result_cnt` ends at 3.
- Saturation:
  - `i_y=32'h20000000` -> `16'hFFFF`.
  - `i_y=32'h1FFFF000` (round overflow) -> `16'hFFFF`.
  - `i_y=32'h1FFFE000` -> `16'hFFFF` without saturation.
  - `o_sat_cnt` ends at 2.
- Fill and back-pressure:
  - Hold `i_ready`=0 and write 5 words with `i_valid`=1 and DEPTH=4. `o_ready` falls after the 4th write and the 5th word is held upstream.
  - Raise `i_ready`: the words drain in order, `o_ready` rises one cycle after the first read, and the 5th word is accepted.
- Streaming: with `i_valid`=`i_ready`=1 continuously for 20 cycles, 20 results come out in order and occupancy never exceeds 1.
- Counter saturation: with `CNTW`=4, write 20 saturating words -> both counters hold at `4'hF`.
- Asynchronous reset: pull `reset` low mid-stream with 3 words buffered. `o_valid`=0, `o_ready`=0 and the counters are 0 immediately. After release, `o_ready`=1 and the next write is the new head.
